fusion_ctrl: RTL and testbench

- Timing and mode controller for the IR/CCD fusion pipeline (two gauss filters, fusion core, pseudo-colour LUT).
- Detects input frame start from xcount_im/ycount_im and locks to the input frame length.
- Regenerates output-aligned x/y counters, valid and frame-sync delayed by the pipeline latency.
- Applies mode changes and window-start changes only on output frame boundaries, so no frame is split between two settings.

---
 rtl/fusion_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fusion_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fusion_ctrl.sv
// Timing and mode controller for the IR/CCD fusion pipeline: locks to the input
// frame, regenerates latency-aligned output counters and switches modes on frame edges.
module fusion_ctrl #(
    parameter int unsigned PERIOD_X = 864,
    parameter int unsigned PERIOD_Y = 625,
    parameter int unsigned LAT      = 1736
) (
    input  logic       pixelclk_is,
    input  logic       reset_is,
    input  logic [9:0] YSTART_IM,
    input  logic [9:0] XSTART_IM,
    input  logic [9:0] ycount_im,
    input  logic [9:0] xcount_im,
    input  logic [3:0] mode_im,
    output logic [9:0] YSTART_OM,
    output logic [9:0] XSTART_OM,
    output logic [9:0] ycount_om,
    output logic [9:0] xcount_om,
    output logic       valid_o,
    output logic       sof_o,
    output logic [1:0] sel_o,
    output logic       gray_o,
    output logic       lock_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned FLEN     = PERIOD_X * PERIOD_Y;
    localparam logic [19:0] FLEN_M1  = 20'(FLEN - 1);
    localparam logic [19:0] FMISS    = 20'(FLEN + PERIOD_X);
    localparam logic [9:0]  X_LAST   = 10'(PERIOD_X - 1);
    localparam logic [9:0]  Y_LAST   = 10'(PERIOD_Y - 1);
    // Output (0,0) must be visible LAT cycles after the input SOF cycle, so the
    // fill count is LAT-2 and LAT==1 starts the output straight from the SOF edge.
    localparam logic [17:0] LAT_LOAD = (LAT > 1) ? 18'(LAT - 2) : 18'd0;
    localparam bit          DIRECT   = (LAT == 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t      state, state_nx;
    logic        prev_zero, in_zero, sof_in;
    logic [19:0] fcnt;
    logic [17:0] lcnt;
    logic [3:0]  mode_pend, mode_act;
    logic [9:0]  ystart_pend, xstart_pend;
    logic        frame_err, frame_miss, x_wrap, y_wrap;
    logic        do_load, do_start, do_drop, do_err;

    assign in_zero    = (xcount_im == '0) && (ycount_im == '0);
    assign sof_in     = in_zero && !prev_zero;
    assign frame_err  = sof_in && (state != IDLE) && (fcnt != FLEN_M1);
    assign frame_miss = !sof_in && (state != IDLE) && (fcnt == FMISS);
    assign x_wrap     = (xcount_om == X_LAST);
    assign y_wrap     = (ycount_om == Y_LAST);

    always_ff @(posedge pixelclk_is or posedge reset_is) begin
        if (reset_is) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        do_load  = 1'b0;
        do_start = 1'b0;
        do_drop  = 1'b0;
        do_err   = 1'b0;
        case (state)
            IDLE: begin
                if (sof_in) begin
                    do_start = DIRECT;
                    do_load  = !DIRECT;
                    if (DIRECT) state_nx = RUN;
                    else        state_nx = FILL;
                end
            end
            FILL, RUN: begin
                if (frame_err) begin
                    do_err   = 1'b1;
                    do_drop  = 1'b1;
                    do_start = DIRECT;
                    do_load  = !DIRECT;
                    if (DIRECT) state_nx = RUN;
                    else        state_nx = FILL;
                end else if (frame_miss) begin
                    do_err   = 1'b1;
                    do_drop  = 1'b1;
                    state_nx = IDLE;
                end else if ((state == FILL) && (lcnt == '0)) begin
                    do_start = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pixelclk_is or posedge reset_is) begin
        if (reset_is) begin
            prev_zero   <= 1'b0;
            fcnt        <= '0;
            lcnt        <= '0;
            mode_pend   <= '0;
            mode_act    <= '0;
            ystart_pend <= '0;
            xstart_pend <= '0;
            YSTART_OM   <= '0;
            XSTART_OM   <= '0;
            ycount_om   <= '0;
            xcount_om   <= '0;
            valid_o     <= 1'b0;
            sof_o       <= 1'b0;
            lock_o      <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            prev_zero <= in_zero;
            if (sof_in)          fcnt <= '0;
            else if (fcnt != '1) fcnt <= fcnt + 1'b1;

            if (sof_in) begin
                mode_pend   <= mode_im;
                ystart_pend <= YSTART_IM;
                xstart_pend <= XSTART_IM;
            end

            if (do_load)                             lcnt <= LAT_LOAD;
            else if ((state == FILL) && (lcnt != '0)) lcnt <= lcnt - 1'b1;

            if (do_err && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;

            sof_o <= 1'b0;
            if (do_start) begin
                xcount_om <= '0;
                ycount_om <= '0;
                sof_o     <= 1'b1;
                valid_o   <= 1'b1;
                lock_o    <= 1'b1;
                mode_act  <= mode_pend;
                YSTART_OM <= ystart_pend;
                XSTART_OM <= xstart_pend;
            end else if (do_drop) begin
                valid_o <= 1'b0;
                lock_o  <= 1'b0;
            end else if (state == RUN) begin
                if (x_wrap) begin
                    xcount_om <= '0;
                    if (y_wrap) begin
                        ycount_om <= '0;
                        sof_o     <= 1'b1;
                        mode_act  <= mode_pend;
                        YSTART_OM <= ystart_pend;
                        XSTART_OM <= xstart_pend;
                    end else begin
                        ycount_om <= ycount_om + 1'b1;
                    end
                end else begin
                    xcount_om <= xcount_om + 1'b1;
                end
            end
        end
    end

    // Reserved modes 4..15 fall through to fusion.
    always_comb begin
        sel_o  = 2'd0;
        gray_o = 1'b0;
        case (mode_act)
            4'd1:    sel_o  = 2'd1;
            4'd2:    sel_o  = 2'd2;
            4'd3:    gray_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fusion_ctrl.sv
// Bench for fusion_ctrl: a frame-level model (output position derived from the
// lock time) checked every cycle, plus directed literal checks from the test plan.
module tb_fusion_ctrl;

    localparam int PX = 8;
    localparam int PY = 4;
    localparam int LAT = 5;
    localparam int FLEN = PX * PY;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] ys_in, xs_in, y_in, x_in;
    logic [3:0] mode_in;
    logic [9:0] ys_out, xs_out, y_out, x_out;
    logic       valid_o, sof_o, gray_o, lock_o;
    logic [1:0] sel_o;
    logic [7:0] err_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    fusion_ctrl #(.PERIOD_X(PX), .PERIOD_Y(PY), .LAT(LAT)) dut (
        .pixelclk_is(clk), .reset_is(rst),
        .YSTART_IM(ys_in), .XSTART_IM(xs_in), .ycount_im(y_in), .xcount_im(x_in),
        .mode_im(mode_in),
        .YSTART_OM(ys_out), .XSTART_OM(xs_out), .ycount_om(y_out), .xcount_om(x_out),
        .valid_o(valid_o), .sof_o(sof_o), .sel_o(sel_o), .gray_o(gray_o),
        .lock_o(lock_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sel_of(input int m);
        if (m == 1) return 1;
        if (m == 2) return 2;
        return 0;
    endfunction

    function automatic int gray_of(input int m);
        return (m == 3) ? 1 : 0;
    endfunction

    // ---------------- frame-level model ----------------
    int mc = 0;
    int armed, running, lock_at, last_sof, hx, hy, err_m;
    int pend_m, act_m, pys, pxs, ays, axs, prev_z;

    always @(negedge clk) begin : monitor
        int e_x, e_y, e_sof, e_valid, pp, old_pend, old_ys, old_xs, in_z, sof, s;
        if (rst) begin
            armed = 0; running = 0; lock_at = 0; last_sof = 0; hx = 0; hy = 0;
            err_m = 0; pend_m = 0; act_m = 0; pys = 0; pxs = 0; ays = 0; axs = 0;
            prev_z = 0;
        end
        if (running != 0 && mc >= lock_at) begin
            pp = (mc - lock_at) % FLEN;
            e_x = pp % PX; e_y = pp / PX; e_sof = (pp == 0); e_valid = 1;
        end else begin
            e_x = hx; e_y = hy; e_sof = 0; e_valid = 0;
        end
        chk("xcount_om", x_out, e_x);
        chk("ycount_om", y_out, e_y);
        chk("sof_o", sof_o, e_sof);
        chk("valid_o", valid_o, e_valid);
        chk("lock_o", lock_o, e_valid);
        chk("err_cnt_o", err_cnt_o, err_m);
        chk("sel_o", sel_o, sel_of(act_m));
        chk("gray_o", gray_o, gray_of(act_m));
        chk("YSTART_OM", ys_out, ays);
        chk("XSTART_OM", xs_out, axs);

        if (!rst) begin
            old_pend = pend_m; old_ys = pys; old_xs = pxs;
            in_z = (x_in == 0 && y_in == 0);
            sof = in_z && !prev_z;
            prev_z = in_z;
            if (sof) begin
                if (armed != 0 && (mc - last_sof) != FLEN) begin
                    if (err_m < 255) err_m++;
                    hx = e_x; hy = e_y;
                    lock_at = mc + LAT; running = 1;
                end else if (armed == 0) begin
                    armed = 1; running = 1; lock_at = mc + LAT;
                end
                last_sof = mc;
            end else if (armed != 0 && (mc - last_sof) == FLEN + PX + 1) begin
                if (err_m < 255) err_m++;
                hx = e_x; hy = e_y;
                armed = 0; running = 0;
            end
            s = mc + 1;
            if (running != 0 && s >= lock_at && ((s - lock_at) % FLEN) == 0) begin
                act_m = old_pend; ays = old_ys; axs = old_xs;
            end
            if (sof) begin
                pend_m = mode_in; pys = ys_in; pxs = xs_in;
            end
        end
        mc++;
    end

    // ---------------- directed stimulus ----------------
    int p;

    task automatic put(input int pos);
        x_in = 10'(pos % PX);
        y_in = 10'(pos / PX);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode_in = 4'd0; ys_in = 10'd7; xs_in = 10'd3;
        p = 21; put(p);
        repeat (3) tick();
        chk("reset valid_o", valid_o, 0);
        chk("reset sof_o", sof_o, 0);
        chk("reset err_cnt_o", err_cnt_o, 0);

        tick();
        rst = 1'b0;
        p = 22; put(p);                 // cycle 0; input SOF lands at cycle 10
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (i == 222)                  p = 0;          // short frame: 20 clocks
            else if (i >= 260 && i <= 304) p = 5;          // input counters stall
            else                           p = (p + 1) % FLEN;
            put(p);

            if (i == 85)  mode_in = 4'd1;                  // at input pixel (3,1)
            if (i == 120) mode_in = 4'd3;
            if (i == 150) mode_in = 4'd9;

            case (i)
                14: chk("pre-lock valid_o", valid_o, 0);
                15: begin
                    chk("lock sof_o", sof_o, 1);
                    chk("lock xcount_om", x_out, 0);
                    chk("lock ycount_om", y_out, 0);
                    chk("lock valid_o", valid_o, 1);
                    chk("lock lock_o", lock_o, 1);
                    chk("lock YSTART_OM", ys_out, 7);
                    chk("lock XSTART_OM", xs_out, 3);
                end
                16: begin
                    chk("lock+1 xcount_om", x_out, 1);
                    chk("lock+1 sof_o", sof_o, 0);
                end
                46: chk("frame end sof_o", sof_o, 0);
                47: chk("second sof_o", sof_o, 1);
                79: begin
                    chk("frame n sof_o", sof_o, 1);
                    chk("frame n sel_o", sel_o, 0);
                end
                110: chk("frame n last sel_o", sel_o, 0);
                111: begin
                    chk("frame n+1 sof_o", sof_o, 1);
                    chk("frame n+1 sel_o", sel_o, 1);
                end
                142: chk("before gray gray_o", gray_o, 0);
                143: begin
                    chk("mode3 gray_o", gray_o, 1);
                    chk("mode3 sel_o", sel_o, 0);
                end
                174: chk("before mode9 gray_o", gray_o, 1);
                175: begin
                    chk("mode9 gray_o", gray_o, 0);
                    chk("mode9 sel_o", sel_o, 0);
                end
                223: begin
                    chk("short valid_o", valid_o, 0);
                    chk("short lock_o", lock_o, 0);
                    chk("short err_cnt_o", err_cnt_o, 1);
                end
                226: chk("short relock-1 valid_o", valid_o, 0);
                227: begin
                    chk("short relock sof_o", sof_o, 1);
                    chk("short relock valid_o", valid_o, 1);
                end
                295: begin
                    chk("pre-miss valid_o", valid_o, 1);
                    chk("pre-miss err_cnt_o", err_cnt_o, 1);
                end
                296: begin
                    chk("miss valid_o", valid_o, 0);
                    chk("miss lock_o", lock_o, 0);
                    chk("miss err_cnt_o", err_cnt_o, 2);
                end
                335: chk("miss relock-1 valid_o", valid_o, 0);
                336: begin
                    chk("miss relock sof_o", sof_o, 1);
                    chk("miss relock xcount_om", x_out, 0);
                    chk("miss relock ycount_om", y_out, 0);
                end
                354: begin
                    chk("pre-reset ycount_om", y_out, 2);
                    chk("pre-reset YSTART_OM", ys_out, 7);
                    #2;
                    rst = 1'b1;
                    #1;
                    chk("async rst valid_o", valid_o, 0);
                    chk("async rst lock_o", lock_o, 0);
                    chk("async rst ycount_om", y_out, 0);
                    chk("async rst xcount_om", x_out, 0);
                    chk("async rst err_cnt_o", err_cnt_o, 0);
                    chk("async rst YSTART_OM", ys_out, 0);
                    chk("async rst XSTART_OM", xs_out, 0);
                    ys_in = 10'd100;
                    xs_in = 10'd37;
                end
                357: rst = 1'b0;
                367: begin
                    chk("pre-relock YSTART_OM", ys_out, 0);
                    chk("pre-relock valid_o", valid_o, 0);
                end
                368: begin
                    chk("relock sof_o", sof_o, 1);
                    chk("relock YSTART_OM", ys_out, 100);
                    chk("relock XSTART_OM", xs_out, 37);
                end
                default: ;
            endcase
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
